z80_ld_ind_nn_a_seq: RTL and testbench
======================================

// Module: z80_ld_ind_nn_a_seq
// PURPOSE
//  Bus sequencer that executes LD (nn),A (opcode 0x32), the store counterpart of LD A,(nn).
//  Runs after the fetch unit has completed M1 and decoded 0x32. Fetches nn low/high bytes
//  (M2, M3), then writes A to address nn (M4). Emits a z80fi-style retirement record that a
//  formal spec checks: IP+3, CYCLE_RDWR_MEM x3, 3 T-states each, plus wait states.
// PARAMETERS
//  WAIT_EN   1     1: honour bus_wait at end of T2 (insert Tw); 0: ignore bus_wait
//  OPCODE    8'h32 opcode byte placed in rec_insn[7:0]
// PORTS
//  clk         in   1   system clock; one clk cycle = one T-state
//  reset_n     in   1   asynchronous, active-low reset
//  start       in   1   1-cycle pulse: M1 of 0x32 finished; ignored unless idle
//  ip_in       in   16  IP of the opcode byte
//  reg_a       in   8   value of A, sampled on start
//  bus_rdata   in   8   read data, sampled on the clk edge that ends T3 of a read
//  bus_wait    in   1   wait request, sampled on the clk edge that ends T2 (and each Tw)
//  bus_addr    out  16  address, valid T1..T3 (incl. Tw) of each M-cycle
//  bus_wdata   out  8   write data, valid T1..T3 of M4
//  bus_mreq    out  1   memory request, high T1..T3 of every M-cycle
//  bus_rd      out  1   read strobe, high T1..T3 of M2/M3
//  bus_wr      out  1   write strobe, high T2 and Tw of M4 only
//  busy        out  1   high from the cycle after start until done
//  done        out  1   1-cycle pulse; all rec_* outputs valid in this cycle
//  ip_out      out  16  ip_in + 3 (mod 2^16)
//  rec_insn    out  24  {nn_hi, nn_lo, OPCODE}
//  rec_waddr   out  16  nn
//  rec_wdata   out  8   A as written
//  rec_mcycles out  3   M-cycles executed (4 incl. M1)
//  rec_tstates out  8   T-states in M2..M4: 9 + total Tw count, saturating at 255
// BEHAVIOUR
//  Reset: asynchronous; state IDLE; every output 0; internal ip, A, nn cleared.
//  FSM: IDLE -> RD_LO -> RD_HI -> WR -> DONE -> IDLE.
//   IDLE: on start, latch ip_in and reg_a, go to RD_LO T1 next cycle (busy=1).
//   RD_LO: addr = ip+1; at end of T3, latch nn_lo.
//   RD_HI: addr = ip+2; at end of T3, latch nn_hi.
//   WR: addr = {nn_hi, nn_lo}; wdata = A; wr high in T2/Tw only.
//   DONE: one cycle; done=1, busy=0, strobes 0; rec_*/ip_out hold until the next start.
//  T-states: 2-bit counter T1 -> T2 -> T3. At end of T2, if WAIT_EN && bus_wait, stay in
//   a Tw (same outputs as T2); re-sample each cycle; no timeout.
//  Latency with no waits: start at cycle 0 -> M2 T1 at cycle 1 -> done at cycle 10.
//  Address arithmetic is 16-bit wrap: ip=FFFE reads FFFF then 0000; ip_out = 0001.
//  Back-to-back: start arriving while DONE is high is accepted (next cycle = RD_LO T1).
//   start while busy is ignored.
//  A is the value latched at start; later changes on reg_a do not affect the write.
//  Reset asserted mid-op: bus strobes drop asynchronously; no done; the op is lost.
// STRUCTURE
//  z80.vh: CYCLE_* M-cycle type codes and OPCODE_LD_IND_NN_A; FSM state enum stays local.
//  Sub-module z80_mcycle_timer: T-state counter with wait insertion. Inputs: go, wait_en,
//   bus_wait. Outputs: t1/t2/t3 flags, last_t (end of T3), tw_count increment.
//   Reused by later memory and IO sequencers.
// TESTING
//  1) ip=0x1000, A=0x5A, rdata 0x34 then 0x12, no wait -> reads 1001/1002, write 5A @1234;
//     done at cycle 10; ip_out=1003; rec_insn=0x123432; rec_tstates=9.
//  2) bus_wait high for 2 cycles in M2 and 1 in M4 -> strobes stretched; done at cycle 13;
//     rec_tstates=12.
//  3) WAIT_EN=0, bus_wait stuck high -> timing identical to (1).
//  4) ip=0xFFFE, nn=0xFFFF -> read addrs FFFF, 0000; write @FFFF; ip_out=0x0001.
//  5) reset_n low during M3 T2 -> mreq/rd drop with no clk edge; no done; fresh start after
//     release gives result (1).
//  6) start pulsed in M2 (ignored), then during DONE (accepted) -> exactly 2 done pulses.
//     Second op uses the A latched at its own start.

Source files
------------

// File: rtl/z80_ld_ind_nn_a_seq_pkg.sv
// rtl/z80_ld_ind_nn_a_seq_pkg.sv - shared Z80 bus-sequencer codes, T-state enum and helpers
package z80_ld_ind_nn_a_seq_pkg;

   localparam logic [1:0] CYCLE_FETCH    = 2'd0;
   localparam logic [1:0] CYCLE_RDWR_MEM = 2'd1;
   localparam logic [1:0] CYCLE_RDWR_IO  = 2'd2;
   localparam logic [1:0] CYCLE_INTERNAL = 2'd3;

   localparam logic [7:0] OPCODE_LD_IND_NN_A = 8'h32;
   localparam logic [7:0] TSTATES_BASE       = 8'd9;
   localparam logic [2:0] MCYCLES_LD_IND_NN_A = 3'd4;

   typedef enum logic [1:0] {
      T_1 = 2'd0,
      T_2 = 2'd1,
      T_3 = 2'd2
   } tstate_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/z80_mcycle_timer.sv
// rtl/z80_mcycle_timer.sv - T1/T2/T3 counter with Tw insertion, shared by memory and IO sequencers
// t_next is the T-state of the following cycle so callers can register their strobes.
module z80_mcycle_timer
   import z80_ld_ind_nn_a_seq_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    go,
   input  logic    wait_en,
   input  logic    bus_wait,
   output tstate_e t_next,
   output logic    last_t,
   output logic    tw_inc
);

   tstate_e t_q;
   tstate_e t_d;

   always_comb begin
      t_d    = t_q;
      tw_inc = go && (t_q == T_2) && wait_en && bus_wait;
      last_t = go && (t_q == T_3);
      if (!go) begin
         t_d = T_1;
      end else begin
         case (t_q)
            T_1:     t_d = T_2;
            T_2:     t_d = tw_inc ? T_2 : T_3;
            T_3:     t_d = T_1;
            default: t_d = T_1;
         endcase
      end
      t_next = t_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) t_q <= T_1;
      else        t_q <= t_d;
   end

endmodule

// File: rtl/z80_ld_ind_nn_a_seq.sv
// rtl/z80_ld_ind_nn_a_seq.sv - LD (nn),A bus sequencer: reads nn (M2/M3), writes A to nn (M4)
// All bus and record outputs are registered from next-state values.
module z80_ld_ind_nn_a_seq
   import z80_ld_ind_nn_a_seq_pkg::*;
#(
   parameter bit         WAIT_EN = 1'b1,
   parameter logic [7:0] OPCODE  = OPCODE_LD_IND_NN_A
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] ip_in,
   input  logic [7:0]  reg_a,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_wait,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_mreq,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic        busy,
   output logic        done,
   output logic [15:0] ip_out,
   output logic [23:0] rec_insn,
   output logic [15:0] rec_waddr,
   output logic [7:0]  rec_wdata,
   output logic [2:0]  rec_mcycles,
   output logic [7:0]  rec_tstates
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_WR,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] ip_q, ip_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  nn_lo_q, nn_lo_d;
   logic [7:0]  nn_hi_q, nn_hi_d;
   logic [7:0]  tst_q, tst_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic [7:0]  bus_wdata_q, bus_wdata_d;
   logic        mreq_q, mreq_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] ip_out_q, ip_out_d;
   logic [23:0] rec_insn_q, rec_insn_d;
   logic [15:0] rec_waddr_q, rec_waddr_d;
   logic [7:0]  rec_wdata_q, rec_wdata_d;
   logic [2:0]  rec_mcycles_q, rec_mcycles_d;
   logic [7:0]  rec_tstates_q, rec_tstates_d;

   logic        go;
   tstate_e     t_next;
   logic        last_t;
   logic        tw_inc;

   assign go = (state_q == S_RD_LO) || (state_q == S_RD_HI) || (state_q == S_WR);

   z80_mcycle_timer u_timer (
      .clk      (clk),
      .rst_n    (reset_n),
      .go       (go),
      .wait_en  (WAIT_EN),
      .bus_wait (bus_wait),
      .t_next   (t_next),
      .last_t   (last_t),
      .tw_inc   (tw_inc)
   );

   always_comb begin
      state_d       = state_q;
      ip_d          = ip_q;
      a_d           = a_q;
      nn_lo_d       = nn_lo_q;
      nn_hi_d       = nn_hi_q;
      tst_d         = tw_inc ? sat_inc8(tst_q) : tst_q;
      done_d        = 1'b0;
      ip_out_d      = ip_out_q;
      rec_insn_d    = rec_insn_q;
      rec_waddr_d   = rec_waddr_q;
      rec_wdata_d   = rec_wdata_q;
      rec_mcycles_d = rec_mcycles_q;
      rec_tstates_d = rec_tstates_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ip_d    = ip_in;
               a_d     = reg_a;
               tst_d   = TSTATES_BASE;
               state_d = S_RD_LO;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_LO: if (last_t) begin
            nn_lo_d = bus_rdata;
            state_d = S_RD_HI;
         end
         S_RD_HI: if (last_t) begin
            nn_hi_d = bus_rdata;
            state_d = S_WR;
         end
         S_WR: if (last_t) begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            ip_out_d      = ip_q + 16'd3;
            rec_insn_d    = {nn_hi_q, nn_lo_q, OPCODE};
            rec_waddr_d   = {nn_hi_q, nn_lo_q};
            rec_wdata_d   = a_q;
            rec_mcycles_d = MCYCLES_LD_IND_NN_A;
            rec_tstates_d = tst_q;
         end
         default: state_d = S_IDLE;
      endcase

      // Strobes for the next cycle follow the next state and next T-state.
      bus_addr_d  = 16'h0000;
      bus_wdata_d = 8'h00;
      mreq_d      = 1'b0;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      busy_d      = 1'b0;
      case (state_d)
         S_RD_LO: begin
            bus_addr_d = ip_d + 16'd1;
            mreq_d     = 1'b1;
            rd_d       = 1'b1;
            busy_d     = 1'b1;
         end
         S_RD_HI: begin
            bus_addr_d = ip_d + 16'd2;
            mreq_d     = 1'b1;
            rd_d       = 1'b1;
            busy_d     = 1'b1;
         end
         S_WR: begin
            bus_addr_d  = {nn_hi_d, nn_lo_d};
            bus_wdata_d = a_d;
            mreq_d      = 1'b1;
            wr_d        = (t_next == T_2);
            busy_d      = 1'b1;
         end
         default: begin
            bus_addr_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         ip_q          <= 16'h0000;
         a_q           <= 8'h00;
         nn_lo_q       <= 8'h00;
         nn_hi_q       <= 8'h00;
         tst_q         <= 8'h00;
         bus_addr_q    <= 16'h0000;
         bus_wdata_q   <= 8'h00;
         mreq_q        <= 1'b0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         ip_out_q      <= 16'h0000;
         rec_insn_q    <= 24'h000000;
         rec_waddr_q   <= 16'h0000;
         rec_wdata_q   <= 8'h00;
         rec_mcycles_q <= 3'd0;
         rec_tstates_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         ip_q          <= ip_d;
         a_q           <= a_d;
         nn_lo_q       <= nn_lo_d;
         nn_hi_q       <= nn_hi_d;
         tst_q         <= tst_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         mreq_q        <= mreq_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         ip_out_q      <= ip_out_d;
         rec_insn_q    <= rec_insn_d;
         rec_waddr_q   <= rec_waddr_d;
         rec_wdata_q   <= rec_wdata_d;
         rec_mcycles_q <= rec_mcycles_d;
         rec_tstates_q <= rec_tstates_d;
      end
   end

   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_mreq    = mreq_q;
   assign bus_rd      = rd_q;
   assign bus_wr      = wr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ip_out      = ip_out_q;
   assign rec_insn    = rec_insn_q;
   assign rec_waddr   = rec_waddr_q;
   assign rec_wdata   = rec_wdata_q;
   assign rec_mcycles = rec_mcycles_q;
   assign rec_tstates = rec_tstates_q;

endmodule

// File: tb/tb_z80_ld_ind_nn_a_seq.sv
// tb/tb_z80_ld_ind_nn_a_seq.sv - scoreboard bench for the LD (nn),A sequencer
module tb_z80_ld_ind_nn_a_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] ip_in = 16'h0000;
   logic [7:0]  reg_a = 8'h00;
   logic [7:0]  bus_rdata = 8'h00;
   logic        bus_wait = 1'b0;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_mreq, bus_rd, bus_wr, busy, done;
   logic [15:0] ip_out, rec_waddr;
   logic [23:0] rec_insn;
   logic [7:0]  rec_wdata, rec_tstates;
   logic [2:0]  rec_mcycles;

   logic [15:0] nw_bus_addr, nw_ip_out, nw_rec_waddr;
   logic [7:0]  nw_bus_wdata, nw_rec_wdata, nw_rec_tstates;
   logic        nw_mreq, nw_rd, nw_wr, nw_busy, nw_done;
   logic [23:0] nw_rec_insn;
   logic [2:0]  nw_rec_mcycles;

   always #5 clk = ~clk;

   z80_ld_ind_nn_a_seq #(.WAIT_EN(1'b1), .OPCODE(8'h32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ip_in(ip_in), .reg_a(reg_a),
      .bus_rdata(bus_rdata), .bus_wait(bus_wait), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_mreq(bus_mreq), .bus_rd(bus_rd), .bus_wr(bus_wr), .busy(busy), .done(done),
      .ip_out(ip_out), .rec_insn(rec_insn), .rec_waddr(rec_waddr), .rec_wdata(rec_wdata),
      .rec_mcycles(rec_mcycles), .rec_tstates(rec_tstates)
   );

   z80_ld_ind_nn_a_seq #(.WAIT_EN(1'b0), .OPCODE(8'h32)) dut_nw (
      .clk(clk), .reset_n(reset_n), .start(start), .ip_in(ip_in), .reg_a(reg_a),
      .bus_rdata(bus_rdata), .bus_wait(1'b1), .bus_addr(nw_bus_addr), .bus_wdata(nw_bus_wdata),
      .bus_mreq(nw_mreq), .bus_rd(nw_rd), .bus_wr(nw_wr), .busy(nw_busy), .done(nw_done),
      .ip_out(nw_ip_out), .rec_insn(nw_rec_insn), .rec_waddr(nw_rec_waddr),
      .rec_wdata(nw_rec_wdata), .rec_mcycles(nw_rec_mcycles), .rec_tstates(nw_rec_tstates)
   );

   typedef struct {
      logic [15:0] ip;
      logic [15:0] nn;
      logic [7:0]  a;
      int          waits;
      int          wr_waits;
      int          start_cyc;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  mem [0:65535];
   logic [31:0] wait_mask = 32'h0;
   int          cyc = 0;
   int          cur_start = 0;
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          rd_idx = 0;
   int          wr_cyc = 0;
   int          mreq_cyc = 0;
   logic        wr_seen = 1'b0;
   logic        prev_rd = 1'b0;
   logic [15:0] last_rd_addr = 16'h0;
   logic        nw_check = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Memory and wait-state model, driven away from the active edge.
   always @(negedge clk) begin
      int off;
      off = cyc - cur_start;
      bus_rdata = bus_rd ? mem[bus_addr] : 8'h00;
      bus_wait  = (off >= 0 && off < 32) ? wait_mask[off] : 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         rd_idx = 0; wr_seen = 1'b0; wr_cyc = 0; mreq_cyc = 0; prev_rd = 1'b0;
      end else begin
         if (bus_rd && (!prev_rd || bus_addr != last_rd_addr)) begin
            if (sbq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_addr", 32'(bus_addr), 32'(16'(sbq[0].ip + 16'(rd_idx + 1))));
            rd_idx++;
         end
         prev_rd = bus_rd;
         last_rd_addr = bus_addr;
         if (bus_mreq) mreq_cyc++;
         if (bus_wr) wr_cyc++;
         if (bus_wr && !wr_seen) begin
            wr_seen = 1'b1;
            if (sbq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
               check("wr_addr", 32'(bus_addr), 32'(sbq[0].nn));
               check("wr_data", 32'(bus_wdata), 32'(sbq[0].a));
            end
         end
         if (done) begin
            done_cnt++;
            if (sbq.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
               e = sbq.pop_front();
               check("latency", 32'(cyc - e.start_cyc), 32'(10 + e.waits));
               check("ip_out", 32'(ip_out), 32'(16'(e.ip + 16'd3)));
               check("rec_insn", 32'(rec_insn), 32'({e.nn, 8'h32}));
               check("rec_waddr", 32'(rec_waddr), 32'(e.nn));
               check("rec_wdata", 32'(rec_wdata), 32'(e.a));
               check("rec_mcycles", 32'(rec_mcycles), 32'd4);
               check("rec_tstates", 32'(rec_tstates), 32'(9 + e.waits));
               check("busy_in_done", 32'(busy), 32'd0);
               check("mreq_in_done", 32'(bus_mreq), 32'd0);
               check("mreq_cycles", 32'(mreq_cyc), 32'(9 + e.waits));
               check("wr_cycles", 32'(wr_cyc), 32'(1 + e.wr_waits));
               check("rd_count", 32'(rd_idx), 32'd2);
               if (nw_check) begin
                  check("nw_done", 32'(nw_done), 32'd1);
                  check("nw_ip_out", 32'(nw_ip_out), 32'(16'(e.ip + 16'd3)));
                  check("nw_rec_insn", 32'(nw_rec_insn), 32'({e.nn, 8'h32}));
                  check("nw_rec_wdata", 32'(nw_rec_wdata), 32'(e.a));
                  check("nw_rec_tstates", 32'(nw_rec_tstates), 32'd9);
               end
            end
            rd_idx = 0; wr_seen = 1'b0; wr_cyc = 0; mreq_cyc = 0;
         end
      end
   end

   task automatic drive_start(input logic [15:0] ip, input logic [7:0] a, input int waits,
                              input int wr_waits, input logic [31:0] mask);
      exp_t e;
      logic [15:0] lo_addr, hi_addr;
      lo_addr = ip + 16'd1;
      hi_addr = ip + 16'd2;
      wait_mask = mask;
      ip_in = ip; reg_a = a; start = 1'b1;
      cur_start = cyc;
      e.ip = ip; e.nn = {mem[hi_addr], mem[lo_addr]}; e.a = a;
      e.waits = waits; e.wr_waits = wr_waits; e.start_cyc = cyc;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      reg_a = 8'($urandom);
      ip_in = 16'($urandom);
   endtask

   task automatic wait_dones(input int target);
      int n = 0;
      while (done_cnt < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_count", 32'(done_cnt), 32'(target));
   endtask

   initial begin
      int base;
      int n;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[16'h1001] = 8'h34; mem[16'h1002] = 8'h12;
      mem[16'hFFFF] = 8'hFF; mem[16'h0000] = 8'hFF;
      mem[16'h2001] = 8'h78; mem[16'h2002] = 8'h56;
      mem[16'h3001] = 8'hBC; mem[16'h3002] = 8'h9A;

      repeat (3) @(negedge clk);
      check("rst_mreq", 32'(bus_mreq), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(bus_addr), 32'd0);
      check("rst_ip_out", 32'(ip_out), 32'd0);
      check("rst_rec_insn", 32'(rec_insn), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      nw_check = 1'b1;
      drive_start(16'h1000, 8'h5A, 0, 0, 32'h0);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_dones(1);

      @(negedge clk);
      nw_check = 1'b0;
      drive_start(16'h1000, 8'hA7, 3, 1, 32'h0000_040C);
      wait_dones(2);
      repeat (4) @(negedge clk);

      nw_check = 1'b1;
      drive_start(16'hFFFE, 8'h3C, 0, 0, 32'h0);
      wait_dones(3);
      check("wrap_ip_out", 32'(ip_out), 32'h0001);
      @(negedge clk);

      drive_start(16'h1000, 8'h5A, 0, 0, 32'h0);
      while (cyc - cur_start < 5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_mreq", 32'(bus_mreq), 32'd0);
      check("async_rd", 32'(bus_rd), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      sbq.delete();
      base = done_cnt;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("no_done_after_reset", 32'(done_cnt), 32'(base));
      drive_start(16'h1000, 8'h5A, 0, 0, 32'h0);
      wait_dones(base + 1);
      @(negedge clk);

      base = done_cnt;
      drive_start(16'h2000, 8'h11, 0, 0, 32'h0);
      start = 1'b1; ip_in = 16'h4000; reg_a = 8'h77;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("first_done_seen", 32'(done), 32'd1);
      drive_start(16'h3000, 8'hC3, 0, 0, 32'h0);
      wait_dones(base + 2);
      repeat (15) @(negedge clk);
      check("exact_two_dones", 32'(done_cnt), 32'(base + 2));
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
